// File: rtl/cur_blk_fetch.sv
// cur_blk_fetch: reads one 16x16 luma block from frame memory and streams it
// as 32 back-to-back 64-bit beats to the current-block register file.
module cur_blk_fetch #(
    parameter int FRAME_W_WORDS = 22,
    parameter int FRAME_H_BLKS  = 9,
    parameter int ADDR_W        = 16,
    parameter int MEM_LAT       = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [4:0]        blk_x,
    input  logic [4:0]        blk_y,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              mem_re,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [63:0]       mem_data,
    output logic              WE,
    output logic [63:0]       DataOUT
);
    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;
    state_t state, state_nxt;
    logic [4:0] cnt;
    logic [MEM_LAT-1:0] re_dly;
    logic [MEM_LAT:0] re_cat;
    logic legal, accept;
    logic [ADDR_W-1:0] base;
    assign legal  = (int'(blk_x) * 2 + 2 <= FRAME_W_WORDS) && (int'(blk_y) < FRAME_H_BLKS);
    assign accept = state == IDLE && start && legal;
    assign base   = ADDR_W'(int'(blk_y) * 16 * FRAME_W_WORDS + int'(blk_x) * 2);
    assign re_cat = {re_dly, mem_re};
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end
    // DRAIN ends once every issued read has been captured
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = accept ? FETCH : IDLE;
            FETCH:   state_nxt = cnt == 5'd31 ? DRAIN : FETCH;
            DRAIN:   state_nxt = re_dly == '0 ? DONE : DRAIN;
            default: state_nxt = IDLE;
        endcase
    end
    always_comb begin
        busy   = state != IDLE;
        done   = state == DONE;
        mem_re = state == FETCH;
    end
    // Address walks left half, right half, then steps down one frame row
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err      <= 1'b0;
            cnt      <= '0;
            mem_addr <= '0;
            re_dly   <= '0;
            WE       <= 1'b0;
            DataOUT  <= '0;
        end else begin
            err    <= state == IDLE && start && !legal;
            re_dly <= re_cat[MEM_LAT-1:0];
            WE     <= re_dly[MEM_LAT-1];
            if (re_dly[MEM_LAT-1])
                DataOUT <= mem_data;
            if (accept) begin
                cnt      <= '0;
                mem_addr <= base;
            end else if (mem_re) begin
                cnt      <= cnt + 5'd1;
                mem_addr <= mem_addr + (cnt[0] ? ADDR_W'(FRAME_W_WORDS - 1) : ADDR_W'(1));
            end
        end
    end
endmodule

// File: tb/tb_cur_blk_fetch.sv
// tb_cur_blk_fetch: drives a MEM_LAT=1 and a MEM_LAT=3 instance side by side
// and checks every cycle against a frame-memory / register-file model.
module tb_cur_blk_fetch;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_i [2];
    logic [4:0]  blk_x, blk_y;
    logic        busy_o [2];
    logic        done_o [2];
    logic        err_o [2];
    logic        re_o [2];
    logic [15:0] addr_o [2];
    logic        we_o [2];
    logic [63:0] dout_o [2];
    logic [63:0] md0, md1;
    logic [63:0] pipe3 [3];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    localparam logic [63:0] JUNK = 64'hDEAD_BEEF_0BAD_F00D;

    typedef struct {
        logic [4:0] bx;
        logic [4:0] by;
        bit         err;
        int         first;
        int         last;
    } vec_t;
    vec_t tbl [8];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    cur_blk_fetch #(.FRAME_W_WORDS(22), .FRAME_H_BLKS(9), .ADDR_W(16), .MEM_LAT(1)) u_dut1 (
        .clk(clk), .reset(rst_n), .start(start_i[0]), .blk_x(blk_x), .blk_y(blk_y),
        .busy(busy_o[0]), .done(done_o[0]), .err(err_o[0]), .mem_re(re_o[0]),
        .mem_addr(addr_o[0]), .mem_data(md0), .WE(we_o[0]), .DataOUT(dout_o[0]));

    cur_blk_fetch #(.FRAME_W_WORDS(22), .FRAME_H_BLKS(9), .ADDR_W(16), .MEM_LAT(3)) u_dut3 (
        .clk(clk), .reset(rst_n), .start(start_i[1]), .blk_x(blk_x), .blk_y(blk_y),
        .busy(busy_o[1]), .done(done_o[1]), .err(err_o[1]), .mem_re(re_o[1]),
        .mem_addr(addr_o[1]), .mem_data(md1), .WE(we_o[1]), .DataOUT(dout_o[1]));

    function automatic logic [63:0] mem_word(input logic [15:0] a);
        return {a ^ 16'hA55A, ~a, a + 16'h1357, a};
    endfunction

    function automatic logic [15:0] addr_of(input logic [4:0] bx, input logic [4:0] by, input int k);
        int a;
        a = (int'(by) * 16 + k / 2) * 22 + int'(bx) * 2 + k % 2;
        return 16'(a);
    endfunction

    // Frame memory: junk whenever no read was issued, so misaligned capture shows
    always @(posedge clk) begin
        md0      <= re_o[0] ? mem_word(addr_o[0]) : JUNK;
        pipe3[0] <= re_o[1] ? mem_word(addr_o[1]) : JUNK;
        pipe3[1] <= pipe3[0];
        pipe3[2] <= pipe3[1];
    end
    assign md1 = pipe3[2];

    task automatic chk1(input string name, input int i, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d cyc %0d got %0b expected %0b", name, i, cyc, act, exp);
        end
    endtask

    task automatic chk64(input string name, input int i, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d cyc %0d got %0h expected %0h", name, i, cyc, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int i, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s idx%0d got %0d expected %0d", name, i, act, exp);
        end
    endtask

    task automatic chk_zero(input string name);
        for (int i = 0; i < 2; i++) begin
            chk1({name, "_busy"}, i, busy_o[i], 1'b0);
            chk1({name, "_done"}, i, done_o[i], 1'b0);
            chk1({name, "_err"}, i, err_o[i], 1'b0);
            chk1({name, "_re"}, i, re_o[i], 1'b0);
            chk1({name, "_we"}, i, we_o[i], 1'b0);
            chk64({name, "_addr"}, i, 64'(addr_o[i]), 64'h0);
            chk64({name, "_dout"}, i, dout_o[i], 64'h0);
        end
    endtask

    // Called in cycle 0 (after its negedge); returns in the last checked cycle
    task automatic run_block(input logic [4:0] bx, input logic [4:0] by, input logic [1:0] mask,
                             input bit repulse, output bit o_err, output int o_first,
                             output int o_last, output int o_wef, output int o_wel);
        logic [2047:0] rf [2];
        logic [2047:0] exp_blk;
        int  rfc [2];
        int  nre [2];
        int  nwe [2];
        int  ndone [2];
        bit  legal, act;
        int  maxc, lat;
        legal = (int'(bx) * 2 + 2 <= 22) && (int'(by) < 9);
        maxc  = !legal ? 3 : (mask[1] ? 38 : 36);
        for (int k = 0; k < 32; k++) exp_blk[k*64 +: 64] = mem_word(addr_of(bx, by, k));
        for (int i = 0; i < 2; i++) begin
            rf[i] = '0; rfc[i] = 0; nre[i] = 0; nwe[i] = 0; ndone[i] = 0;
        end
        o_err = 1'b0; o_first = -1; o_last = -1; o_wef = -1; o_wel = -1;
        blk_x = bx;
        blk_y = by;
        start_i[0] = mask[0];
        start_i[1] = mask[1];
        for (int c = 1; c <= maxc; c++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                lat = i ? 3 : 1;
                act = mask[i] && legal;
                chk1("busy", i, busy_o[i], act && c <= lat + 34);
                chk1("mem_re", i, re_o[i], act && c <= 32);
                chk1("we", i, we_o[i], act && c >= lat + 2 && c <= lat + 33);
                chk1("done", i, done_o[i], act && c == lat + 34);
                chk1("err", i, err_o[i], mask[i] && !legal && c == 1);
                if (act && c <= 32)
                    chk64("mem_addr", i, 64'(addr_o[i]), 64'(addr_of(bx, by, c - 1)));
                if (act && c >= lat + 2 && c <= lat + 33)
                    chk64("dataout", i, dout_o[i], mem_word(addr_of(bx, by, c - lat - 2)));
                if (act && c > lat + 33)
                    chk64("dataout_hold", i, dout_o[i], mem_word(addr_of(bx, by, 31)));
                if (re_o[i]) nre[i]++;
                if (done_o[i]) ndone[i]++;
                if (we_o[i]) begin
                    if (rfc[i] < 32) rf[i][rfc[i]*64 +: 64] = dout_o[i];
                    rfc[i]++;
                    nwe[i]++;
                end else begin
                    rfc[i] = 0;
                end
            end
            if (c == 1) o_err = err_o[0];
            if (re_o[0]) begin
                if (o_first < 0) o_first = int'(addr_o[0]);
                o_last = int'(addr_o[0]);
            end
            if (we_o[0]) begin
                if (o_wef < 0) o_wef = cyc;
                o_wel = cyc;
            end
            start_i[0] = repulse && (c == 5 || c == 20) && mask[0];
            start_i[1] = repulse && (c == 5 || c == 20) && mask[1];
            if (repulse && c == 5) begin blk_x = 5'd0; blk_y = 5'd1; end
            if (repulse && c == 20) begin blk_x = 5'd31; blk_y = 5'd31; end
        end
        for (int i = 0; i < 2; i++) begin
            act = mask[i] && legal;
            chk_int("reads", i, nre[i], act ? 32 : 0);
            chk_int("beats", i, nwe[i], act ? 32 : 0);
            chk_int("dones", i, ndone[i], act ? 1 : 0);
            if (act) begin
                checks++;
                if (rf[i] !== exp_blk) begin
                    errors++;
                    for (int k = 31; k >= 0; k--)
                        if (rf[i][k*64 +: 64] !== exp_blk[k*64 +: 64]) o_first = k;
                    $display("FAIL rf_block dut%0d first bad beat %0d got %0h expected %0h", i, o_first,
                             rf[i][o_first*64 +: 64], exp_blk[o_first*64 +: 64]);
                end
            end
        end
    endtask

    initial begin
        bit         oe;
        int         of, ol, wf, wl, wl_a;
        logic [4:0] rx, ry;
        start_i[0] = 1'b0;
        start_i[1] = 1'b0;
        blk_x = '0;
        blk_y = '0;
        tbl[0] = '{5'd0,  5'd0,  1'b0, 0,    331};
        tbl[1] = '{5'd10, 5'd8,  1'b0, 2836, 3167};
        tbl[2] = '{5'd11, 5'd0,  1'b1, 0,    0};
        tbl[3] = '{5'd0,  5'd9,  1'b1, 0,    0};
        tbl[4] = '{5'd10, 5'd0,  1'b0, 20,   351};
        tbl[5] = '{5'd0,  5'd8,  1'b0, 2816, 3147};
        tbl[6] = '{5'd5,  5'd3,  1'b0, 1066, 1397};
        tbl[7] = '{5'd31, 5'd31, 1'b1, 0,    0};
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        for (int t = 0; t < 8; t++) begin
            run_block(tbl[t].bx, tbl[t].by, 2'b11, 1'b0, oe, of, ol, wf, wl);
            chk1("tbl_err", t, oe, tbl[t].err);
            if (!tbl[t].err) begin
                chk_int("tbl_first", t, of, tbl[t].first);
                chk_int("tbl_last", t, ol, tbl[t].last);
            end
            @(negedge clk);
        end

        // start re-pulsed mid-transfer must be ignored
        run_block(5'd3, 5'd2, 2'b11, 1'b1, oe, of, ol, wf, wl);
        @(negedge clk);

        // back-to-back on the MEM_LAT=1 instance: start in the first idle cycle
        run_block(5'd2, 5'd4, 2'b01, 1'b0, oe, of, ol, wf, wl);
        wl_a = wl;
        run_block(5'd7, 5'd1, 2'b01, 1'b0, oe, of, ol, wf, wl);
        chk1("we_gap", 0, wf - wl_a - 1 >= 2, 1'b1);
        @(negedge clk);

        // asynchronous reset in cycle 15 of a transfer
        blk_x = 5'd4;
        blk_y = 5'd5;
        start_i[0] = 1'b1;
        start_i[1] = 1'b1;
        @(negedge clk);
        start_i[0] = 1'b0;
        start_i[1] = 1'b0;
        repeat (14) @(negedge clk);
        chk1("busy_pre", 0, busy_o[0], 1'b1);
        chk1("busy_pre", 1, busy_o[1], 1'b1);
        rst_n = 1'b0;
        #1;
        chk_zero("rst_mid");
        repeat (3) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                chk1("rst_hold_done", i, done_o[i], 1'b0);
                chk1("rst_hold_busy", i, busy_o[i], 1'b0);
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
        run_block(5'd9, 5'd7, 2'b11, 1'b0, oe, of, ol, wf, wl);

        for (int n = 0; n < 16; n++) begin
            rx = 5'($urandom_range(0, 12));
            ry = 5'($urandom_range(0, 10));
            run_block(rx, ry, 2'b11, 1'($urandom_range(0, 1)), oe, of, ol, wf, wl);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/cur_blk_fetch.md
Name: cur_blk_fetch

Overview:
- Transmit-side companion to the current-block register file: fetches one 16x16 8-bit luma block from frame memory.
- Streams the block as 32 contiguous 64-bit beats on a WE/DataOUT write interface, matching what the current-block register file consumes.
- Sits between the frame-memory read port and the current-block register file in the motion-estimation datapath.
- The register file restarts its beat count whenever WE drops, so the 32 beats must be back-to-back.

Parameters:
- FRAME_W_WORDS, 22, frame width in 64-bit words (176 pixels / 8).
- FRAME_H_BLKS, 9, frame height in 16-row blocks.
- ADDR_W, 16, frame-memory word-address width.
- MEM_LAT, 1, fixed frame-memory read latency in cycles (1..4).

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- start  in  1  one-cycle request to fetch a block; sampled only when busy=0.
- blk_x  in  5  block column index, in blocks.
- blk_y  in  5  block row index, in blocks.
- busy  out  1  high from the cycle after an accepted start through the done cycle.
- done  out  1  one-cycle pulse after the final beat.
- err  out  1  one-cycle pulse when start is rejected for out-of-range coordinates.
- mem_re  out  1  frame-memory read enable.
- mem_addr  out  ADDR_W  frame-memory word address.
- mem_data  in  64  read data, valid MEM_LAT cycles after mem_re.
- WE  out  1  beat valid to the register file.
- DataOUT  out  64  beat data; pixel 0 of the word sits in the MSBs, passed through unchanged from mem_data.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - busy, done, err, mem_re, WE = 0; mem_addr and DataOUT = 0.
  - The read-enable delay line and the beat counter are cleared.
- Range check on start in IDLE:
  - Legal when blk_x*2+2 <= FRAME_W_WORDS and blk_y < FRAME_H_BLKS.
  - Illegal: err=1 for the next cycle only, state stays IDLE, no reads issued.
- start while busy=1 is ignored: no err, no effect on the current transfer.
- FSM states IDLE -> FETCH -> DRAIN -> DONE -> IDLE.
- Beat k = 0..31 maps to row r = k>>1, half h = k&1.
- mem_addr for beat k = (blk_y*16 + r)*FRAME_W_WORDS + blk_x*2 + h, computed at ADDR_W bits; the address is truncated to ADDR_W bits with no overflow check.
- Beat order is row-major, left half then right half. This matches the register file, which places beat k at its bit offset k*64.
- Timing, with start accepted at cycle 0:
  - FETCH: mem_re=1 on cycles 1..32, one address per cycle, no gaps.
  - DRAIN: entered after the 32nd read, waits for outstanding data.
  - mem_data is captured into the DataOUT register each cycle the delayed read enable is set.
  - WE=1 exactly on cycles MEM_LAT+2 .. MEM_LAT+33 (32 contiguous cycles), with DataOUT = the word read for beat k on cycle MEM_LAT+2+k.
  - DONE: done=1 on cycle MEM_LAT+34; busy deasserts the following cycle.
- DataOUT holds its last value when WE=0 (no forced zero except at reset).
- Back-to-back: a start in the first cycle after busy falls is accepted. The next first mem_re comes one cycle later, so the register file sees WE low for at least 2 cycles between blocks.
- Reset mid-transfer: WE, mem_re and busy drop asynchronously and no done is generated. The register file discards the partial block because WE deasserts.
- Fixed latency: mem_data has no handshake and is never stalled.

Test Plan:
- Block (0,0) with defaults, MEM_LAT=1, start at cycle 0 -> mem_addr 0,1,22,23,...,330,331 on cycles 1..32. Memory returns address as data, so DataOUT shows 0,1,22,...,331 with WE on cycles 3..34; done on cycle 35; err never set.
- Block (10,8) -> first addresses 2836, 2837, 2858; last address 3167. 32 WE beats, and a scoreboard check of the 2048-bit block in a register-file model.
- Out of range: blk_x=11 (24>22) and, separately, blk_y=9 -> err pulse for one cycle, busy stays 0, zero mem_re cycles.
- start re-pulsed at cycles 5 and 20 of a transfer -> ignored. Exactly 32 reads and one done, then a back-to-back start after busy falls fetches a second block with a WE gap of at least 2 cycles.
- reset driven low on cycle 15 of a transfer -> outputs zero immediately, no done. After release, a new start produces a full correct 32-beat block.
- MEM_LAT=3 build -> WE on cycles 5..36, done on cycle 37, data alignment checked beat by beat.
